// File: rtl/if_branch_predictor_if.sv
// Fetch/decode signal bundle for the branch predictor: IF-stage lookup,
// ID-stage resolution feedback, and the flush/redirect and statistics outputs.
interface if_branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic        id_taken;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  if_pc, id_valid, id_is_branch, id_pc, id_taken, id_target,
           id_pred_taken, id_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_cnt, miss_cnt
  );

  modport master (
    output if_pc, id_valid, id_is_branch, id_pc, id_taken, id_target,
           id_pred_taken, id_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/if_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-cycle fetch lookup,
// ID-stage update with mispredict detection, and saturating statistics counters.
module if_branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];
  logic [15:0]      br_cnt_r;
  logic [15:0]      miss_cnt_r;

  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] id_idx_s;
  logic             if_hit_s;
  logic             id_hit_s;
  logic             upd_s;
  logic             mispredict_s;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  assign if_idx_s = bp.if_pc[IDX_W+1:2];
  assign id_idx_s = bp.id_pc[IDX_W+1:2];
  assign upd_s    = bp.id_valid & bp.id_is_branch;

  // Fetch lookup and ID-stage resolution, both read the pre-update table.
  always_comb begin
    if_hit_s       = valid_r[if_idx_s] && (tag_r[if_idx_s] == bp.if_pc[31:2+IDX_W]);
    id_hit_s       = valid_r[id_idx_s] && (tag_r[id_idx_s] == bp.id_pc[31:2+IDX_W]);
    bp.pred_taken  = if_hit_s & ctr_r[if_idx_s][1];
    if (bp.pred_taken) begin
      bp.pred_target = target_r[if_idx_s];
    end else begin
      bp.pred_target = bp.if_pc + 32'd4;
    end
    mispredict_s = upd_s & ((bp.id_taken != bp.id_pred_taken) ||
                   (bp.id_taken & bp.id_pred_taken & (bp.id_target != bp.id_pred_target)));
    if (bp.id_taken) begin
      bp.redirect_pc = bp.id_target;
    end else begin
      bp.redirect_pc = bp.id_pc + 32'd4;
    end
  end

  assign bp.mispredict = mispredict_s;
  assign bp.br_cnt     = br_cnt_r;
  assign bp.miss_cnt   = miss_cnt_r;

  // Table update: train on hits, allocate only on taken misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (upd_s) begin
      if (id_hit_s) begin
        ctr_r[id_idx_s] <= ctr_next(ctr_r[id_idx_s], bp.id_taken);
        if (bp.id_taken) begin
          target_r[id_idx_s] <= bp.id_target;
        end
      end else if (bp.id_taken) begin
        valid_r[id_idx_s]  <= 1'b1;
        tag_r[id_idx_s]    <= bp.id_pc[31:2+IDX_W];
        target_r[id_idx_s] <= bp.id_target;
        ctr_r[id_idx_s]    <= 2'b10;
      end
    end
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r   <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else begin
      if (upd_s && (br_cnt_r != 16'hFFFF)) begin
        br_cnt_r <= br_cnt_r + 16'd1;
      end
      if (mispredict_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_branch_predictor.sv
// Directed-vector bench for if_branch_predictor with hand-computed expectations.
module tb_if_branch_predictor;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  if_branch_predictor_if bp_if ();

  if_branch_predictor #(.IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    bp_if.id_valid       = 1'b1;
    bp_if.id_is_branch   = 1'b1;
    bp_if.id_pc          = pc;
    bp_if.id_taken       = taken;
    bp_if.id_target      = tgt;
    bp_if.id_pred_taken  = ptaken;
    bp_if.id_pred_target = ptgt;
  endtask

  task automatic idle();
    bp_if.id_valid     = 1'b0;
    bp_if.id_is_branch = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_tgt);
    bp_if.if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bp_if.pred_taken}, {31'd0, exp_t});
    check({tag, "_target"}, bp_if.pred_target, exp_tgt);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bp_if.if_pc = 32'h0040_0010;
    set_upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    #2;
    check("rst_pred_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    check("rst_pred_target", bp_if.pred_target, 32'h0040_0014);
    check("rst_br_cnt", {16'd0, bp_if.br_cnt}, 32'd0);
    check("rst_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd0);
    check("rst_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    look("cold", 32'h0040_0010, 1'b0, 32'h0040_0014);

    // Allocate: taken miss, predicted not-taken
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    #1;
    check("alloc_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    check("alloc_redirect", bp_if.redirect_pc, 32'h0040_0100);
    look("same_cycle_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
    tick();
    idle();
    look("alloc_hit", 32'h0040_0010, 1'b1, 32'h0040_0100);
    check("alloc_br_cnt", {16'd0, bp_if.br_cnt}, 32'd1);
    check("alloc_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd1);

    // WT -> ST with three correctly predicted taken updates
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      #1;
      check("sat_t_nomiss", {31'd0, bp_if.mispredict}, 32'd0);
      tick();
      idle();
      look("sat_t", 32'h0040_0010, 1'b1, 32'h0040_0100);
    end
    // ST -> WT
    set_upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    #1;
    check("nt_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    check("nt_redirect", bp_if.redirect_pc, 32'h0040_0014);
    tick();
    idle();
    look("st_to_wt", 32'h0040_0010, 1'b1, 32'h0040_0100);
    // WT -> WNT (mispredicted), WNT -> SNT, SNT -> SNT
    set_upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    tick();
    idle();
    look("wt_to_wnt", 32'h0040_0010, 1'b0, 32'h0040_0014);
    for (int i = 0; i < 2; i++) begin
      set_upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014);
      tick();
      idle();
      look("to_snt", 32'h0040_0010, 1'b0, 32'h0040_0014);
    end
    // A taken update from SNT only reaches WNT, so still not predicted taken
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    tick();
    idle();
    look("snt_held", 32'h0040_0010, 1'b0, 32'h0040_0014);
    check("walk_br_cnt", {16'd0, bp_if.br_cnt}, 32'd9);
    check("walk_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd4);

    // Taken with wrong predicted target: mispredict, WNT -> WT, new target
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
    #1;
    check("tgt_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    check("tgt_redirect", bp_if.redirect_pc, 32'h0040_0200);
    tick();
    idle();
    look("tgt_new", 32'h0040_0010, 1'b1, 32'h0040_0200);

    // Alias replacement at the same index
    set_upd(32'h0040_0050, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0054);
    tick();
    idle();
    look("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
    look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0300);

    // Not-taken miss: no allocation
    set_upd(32'h0040_0090, 1'b0, 32'h0040_0400, 1'b0, 32'h0040_0094);
    #1;
    check("ntmiss_nomiss", {31'd0, bp_if.mispredict}, 32'd0);
    tick();
    idle();
    look("ntmiss_keep", 32'h0040_0050, 1'b1, 32'h0040_0300);
    look("ntmiss_noalloc", 32'h0040_0090, 1'b0, 32'h0040_0094);
    check("ntmiss_br_cnt", {16'd0, bp_if.br_cnt}, 32'd12);
    check("ntmiss_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd6);

    // Not an update event: id_valid=0, then id_is_branch=0
    set_upd(32'h0040_0090, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0094);
    bp_if.id_valid = 1'b0;
    #1;
    check("novalid_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    tick();
    bp_if.id_valid     = 1'b1;
    bp_if.id_is_branch = 1'b0;
    tick();
    idle();
    look("noupd_table", 32'h0040_0090, 1'b0, 32'h0040_0094);
    check("noupd_br_cnt", {16'd0, bp_if.br_cnt}, 32'd12);
    check("noupd_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd6);

    // Drive br_cnt to saturation with correctly predicted not-taken misses
    set_upd(32'h0040_0090, 1'b0, 32'h0040_0400, 1'b0, 32'h0040_0094);
    for (int i = 0; i < 65530; i++) begin
      tick();
    end
    idle();
    check("br_cnt_sat", {16'd0, bp_if.br_cnt}, 32'h0000_FFFF);
    set_upd(32'h0040_0090, 1'b0, 32'h0040_0400, 1'b0, 32'h0040_0094);
    tick();
    idle();
    check("br_cnt_hold", {16'd0, bp_if.br_cnt}, 32'h0000_FFFF);
    check("sat_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd6);

    // Reset mid-cycle with a pending allocation
    set_upd(32'h0040_0090, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0094);
    #3;
    rst_n = 1'b0;
    bp_if.if_pc = 32'h0040_0050;
    #1;
    check("mid_rst_pred", {31'd0, bp_if.pred_taken}, 32'd0);
    check("mid_rst_target", bp_if.pred_target, 32'h0040_0054);
    check("mid_rst_br_cnt", {16'd0, bp_if.br_cnt}, 32'd0);
    check("mid_rst_miss_cnt", {16'd0, bp_if.miss_cnt}, 32'd0);
    check("mid_rst_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    tick();
    idle();
    #2;
    rst_n = 1'b1;
    tick();
    look("post_rst_discard", 32'h0040_0090, 1'b0, 32'h0040_0094);
    check("post_rst_br_cnt", {16'd0, bp_if.br_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
